// File: rtl/reaction_ctrl_pkg.sv
// Package reaction_pkg: shared widths and state encoding for the reaction
// timer controller.
//   TIME_W  : width of time_ms / best_ms (holds 0..9999)
//   RAND_W  : number of rand_in bits added to the minimum delay
//   DELAY_W : width of the ARM delay counter (holds up to 1000 + 4095)
//   state_e : FSM encoding, also exported on the state output
package reaction_pkg;

  localparam int TIME_W  = 14;
  localparam int RAND_W  = 12;
  localparam int DELAY_W = 13;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_GO   = 3'd2,
    ST_DONE = 3'd3,
    ST_FOUL = 3'd4
  } state_e;

endpackage

// File: rtl/reaction_ctrl_if.sv
// Interface reaction_ctrl_if: bundles the controller's stimulus and
// status signals so a driver and a monitor can share one handle.
//   inputs to the controller : tick, rand_in, start_btn, stop_btn
//   outputs of the controller: led_go, count_en, count_clr, time_ms,
//                              best_ms, foul, state
//   master : the side that drives buttons/tick (environment)
//   slave  : the controller side
interface reaction_ctrl_if;
  import reaction_pkg::*;

  logic              tick;
  logic [14:0]       rand_in;
  logic              start_btn;
  logic              stop_btn;
  logic              led_go;
  logic              count_en;
  logic              count_clr;
  logic [TIME_W-1:0] time_ms;
  logic [TIME_W-1:0] best_ms;
  logic              foul;
  logic [2:0]        state;

  modport master (
    output tick, rand_in, start_btn, stop_btn,
    input  led_go, count_en, count_clr, time_ms, best_ms, foul, state
  );

  modport slave (
    input  tick, rand_in, start_btn, stop_btn,
    output led_go, count_en, count_clr, time_ms, best_ms, foul, state
  );

endinterface

// File: rtl/reaction_ctrl_edge_detect.sv
// edge_detect: one-bit rising-edge detector.
//   clk, rst : clock and synchronous active-high reset
//   d_i      : synchronized level input
//   rise_o   : high for the clk in which d_i is high and was low before
// The history register resets to 1 so a level held high through reset is
// not reported as an edge until it has been released and pressed again.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);

  logic hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= 1'b1;
    end else begin
      hist_q <= d_i;
    end
  end

  assign rise_o = d_i & ~hist_q;

endmodule

// File: rtl/reaction_ctrl.sv
// reaction_ctrl: reaction-time game controller.
//   clk, rst   : clock, synchronous active-high reset
//   tick       : 1 ms enable pulse, one clk wide
//   rand_in    : free-running LFSR value; low 12 bits extend the wait
//   start_btn  : start level (press = rising edge)
//   stop_btn   : stop level (press = rising edge)
//   led_go     : high while in GO
//   count_en   : high while in GO, enables the external BCD counter
//   count_clr  : one-clk pulse on each entry to ARM
//   time_ms    : elapsed / result time in ms
//   best_ms    : best valid result since reset (MAX_COUNT when none)
//   foul       : high while in FOUL
//   state      : current FSM state (IDLE=0 ARM=1 GO=2 DONE=3 FOUL=4)
// Every output is a register or a pure decode of the state register.
module reaction_ctrl
  import reaction_pkg::*;
#(
  parameter int MIN_DELAY_MS = 1000,
  parameter int MAX_COUNT    = 9999
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [14:0]       rand_in,
  input  logic              start_btn,
  input  logic              stop_btn,
  output logic              led_go,
  output logic              count_en,
  output logic              count_clr,
  output logic [TIME_W-1:0] time_ms,
  output logic [TIME_W-1:0] best_ms,
  output logic              foul,
  output logic [2:0]        state
);

  localparam logic [TIME_W-1:0]  MAX_T   = TIME_W'(MAX_COUNT);
  localparam logic [DELAY_W-1:0] MIN_DLY = DELAY_W'(MIN_DELAY_MS);

  state_e             state_q, state_d;
  logic [DELAY_W-1:0] delay_q, delay_d;
  logic [TIME_W-1:0]  time_q,  time_d;
  logic [TIME_W-1:0]  best_q,  best_d;
  logic               clr_q,   clr_d;
  logic               start_rise, stop_rise;
  logic [DELAY_W-1:0] delay_load;
  logic               unused_rand_hi;

  edge_detect u_start_ed (
    .clk    (clk),
    .rst    (rst),
    .d_i    (start_btn),
    .rise_o (start_rise)
  );

  edge_detect u_stop_ed (
    .clk    (clk),
    .rst    (rst),
    .d_i    (stop_btn),
    .rise_o (stop_rise)
  );

  // Only the low bits of the LFSR set the random part of the wait.
  assign delay_load     = MIN_DLY + DELAY_W'(rand_in[RAND_W-1:0]);
  assign unused_rand_hi = ^rand_in[14:RAND_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      delay_q <= '0;
      time_q  <= '0;
      best_q  <= MAX_T;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      delay_q <= delay_d;
      time_q  <= time_d;
      best_q  <= best_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    time_d  = time_q;
    best_d  = best_q;
    clr_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_FOUL: begin
        if (start_rise) begin
          state_d = ST_ARM;
          delay_d = delay_load;
          time_d  = '0;
          clr_d   = 1'b1;
        end
      end
      ST_ARM: begin
        // A stop press beats a coincident final tick: it is a foul.
        if (stop_rise) begin
          state_d = ST_FOUL;
          time_d  = '0;
        end else if (tick) begin
          if (delay_q <= DELAY_W'(1)) begin
            delay_d = '0;
            state_d = ST_GO;
          end else begin
            delay_d = delay_q - DELAY_W'(1);
          end
        end
      end
      ST_GO: begin
        // Stop wins over a coincident tick, so that tick is not counted.
        if (stop_rise) begin
          state_d = ST_DONE;
          if (time_q < best_q) begin
            best_d = time_q;
          end
        end else if (time_q >= MAX_T) begin
          // Saturated without a stop: not a valid result, best untouched.
          state_d = ST_DONE;
        end else if (tick) begin
          time_d = time_q + TIME_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        time_d  = '0;
      end
    endcase
  end

  assign led_go    = (state_q == ST_GO);
  assign count_en  = (state_q == ST_GO);
  assign foul      = (state_q == ST_FOUL);
  assign count_clr = clr_q;
  assign time_ms   = time_q;
  assign best_ms   = best_q;
  assign state     = state_q;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Directed testbench for reaction_ctrl with hand-computed expectations.
module tb_reaction_ctrl;
  import reaction_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   clr_seen;

  reaction_ctrl_if bus ();

  reaction_ctrl #(
    .MIN_DELAY_MS (1000),
    .MAX_COUNT    (9999)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (bus.tick),
    .rand_in   (bus.rand_in),
    .start_btn (bus.start_btn),
    .stop_btn  (bus.stop_btn),
    .led_go    (bus.led_go),
    .count_en  (bus.count_en),
    .count_clr (bus.count_clr),
    .time_ms   (bus.time_ms),
    .best_ms   (bus.best_ms),
    .foul      (bus.foul),
    .state     (bus.state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // count_clr pulses observed away from the active edge
  always @(negedge clk) begin
    if (bus.count_clr === 1'b1) clr_seen++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick(input int gap);
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    repeat (gap - 1) step();
  endtask

  task automatic press_start();
    bus.start_btn = 1'b1;
    step();
    bus.start_btn = 1'b0;
  endtask

  task automatic press_stop();
    bus.stop_btn = 1'b1;
    step();
    bus.stop_btn = 1'b0;
  endtask

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp         = 0;
    n_err         = 0;
    clr_seen      = 0;
    rst           = 1'b1;
    bus.tick      = 1'b0;
    bus.rand_in   = 15'd0;
    bus.start_btn = 1'b1;   // held through reset
    bus.stop_btn  = 1'b0;
    repeat (3) step();

    // reset values
    check_eq("rst_state", 32'(bus.state), 32'd0);
    check_eq("rst_time", 32'(bus.time_ms), 32'd0);
    check_eq("rst_best", 32'(bus.best_ms), 32'd9999);
    check_eq("rst_led_go", 32'(bus.led_go), 32'd0);
    check_eq("rst_count_en", 32'(bus.count_en), 32'd0);
    check_eq("rst_count_clr", 32'(bus.count_clr), 32'd0);
    check_eq("rst_foul", 32'(bus.foul), 32'd0);

    rst = 1'b0;
    step();
    check_eq("held_start_no_press", 32'(bus.state), 32'd0);
    bus.start_btn = 1'b0;
    step();

    // round 1: minimum delay, ticks every 10 clk
    bus.rand_in = 15'd0;
    clr_seen    = 0;
    press_start();
    check_eq("arm_entry", 32'(bus.state), 32'd1);
    check_eq("arm_count_clr", 32'(bus.count_clr), 32'd1);
    check_eq("arm_time_clr", 32'(bus.time_ms), 32'd0);
    step();
    for (int i = 0; i < 999; i++) do_tick(10);
    check_eq("arm_after_999", 32'(bus.state), 32'd1);
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    check_eq("go_after_1000", 32'(bus.state), 32'd2);
    check_eq("go_led", 32'(bus.led_go), 32'd1);
    check_eq("go_count_en", 32'(bus.count_en), 32'd1);
    check_eq("clr_once", 32'(clr_seen), 32'd1);
    for (int i = 0; i < 250; i++) do_tick(2);
    check_eq("go_time_250", 32'(bus.time_ms), 32'd250);
    press_stop();
    check_eq("done_state", 32'(bus.state), 32'd3);
    check_eq("done_time_250", 32'(bus.time_ms), 32'd250);
    check_eq("best_250", 32'(bus.best_ms), 32'd250);
    check_eq("done_led", 32'(bus.led_go), 32'd0);
    step();
    press_stop();
    check_eq("stop_in_done_ignored", 32'(bus.state), 32'd3);
    step();

    // round 2: maximum delay, slower result
    bus.rand_in = 15'h7FFF;
    press_start();
    check_eq("arm2_entry", 32'(bus.state), 32'd1);
    check_eq("arm2_time_clr", 32'(bus.time_ms), 32'd0);
    step();
    for (int i = 0; i < 5094; i++) do_tick(2);
    check_eq("arm2_after_5094", 32'(bus.state), 32'd1);
    do_tick(2);
    check_eq("go2_after_5095", 32'(bus.state), 32'd2);
    for (int i = 0; i < 300; i++) do_tick(2);
    press_stop();
    check_eq("done2_time_300", 32'(bus.time_ms), 32'd300);
    check_eq("best_stays_250", 32'(bus.best_ms), 32'd250);
    step();

    // foul: stop coincident with the final ARM tick
    bus.rand_in = 15'd0;
    press_start();
    step();
    for (int i = 0; i < 999; i++) do_tick(2);
    bus.tick     = 1'b1;
    bus.stop_btn = 1'b1;
    step();
    bus.tick     = 1'b0;
    bus.stop_btn = 1'b0;
    check_eq("foul_state", 32'(bus.state), 32'd4);
    check_eq("foul_flag", 32'(bus.foul), 32'd1);
    check_eq("foul_led", 32'(bus.led_go), 32'd0);
    check_eq("foul_time", 32'(bus.time_ms), 32'd0);
    step();
    press_stop();
    check_eq("stop_in_foul_ignored", 32'(bus.state), 32'd4);
    step();
    press_start();
    check_eq("foul_rearm", 32'(bus.state), 32'd1);
    check_eq("foul_cleared", 32'(bus.foul), 32'd0);
    check_eq("rearm_count_clr", 32'(bus.count_clr), 32'd1);
    step();

    // GO: start ignored, stop coincident with tick at 42
    for (int i = 0; i < 1000; i++) do_tick(2);
    check_eq("go3", 32'(bus.state), 32'd2);
    press_start();
    check_eq("start_in_go_ignored", 32'(bus.state), 32'd2);
    step();
    for (int i = 0; i < 42; i++) do_tick(2);
    bus.tick     = 1'b1;
    bus.stop_btn = 1'b1;
    step();
    bus.tick     = 1'b0;
    bus.stop_btn = 1'b0;
    check_eq("tie_state", 32'(bus.state), 32'd3);
    check_eq("tie_time_42", 32'(bus.time_ms), 32'd42);
    check_eq("tie_best_42", 32'(bus.best_ms), 32'd42);
    step();

    // saturation at 9999 without a stop
    press_start();
    step();
    for (int i = 0; i < 1000; i++) do_tick(2);
    for (int i = 0; i < 9998; i++) do_tick(2);
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    check_eq("sat_time_9999", 32'(bus.time_ms), 32'd9999);
    check_eq("sat_still_go", 32'(bus.state), 32'd2);
    step();
    check_eq("sat_done", 32'(bus.state), 32'd3);
    check_eq("sat_time_held", 32'(bus.time_ms), 32'd9999);
    check_eq("sat_best_kept", 32'(bus.best_ms), 32'd42);
    do_tick(2);
    check_eq("done_holds_time", 32'(bus.time_ms), 32'd9999);

    // reset in the middle of GO, start held through it
    press_start();
    step();
    for (int i = 0; i < 1000; i++) do_tick(2);
    for (int i = 0; i < 500; i++) do_tick(2);
    check_eq("pre_rst_time_500", 32'(bus.time_ms), 32'd500);
    rst           = 1'b1;
    bus.start_btn = 1'b1;
    step();
    check_eq("midgo_rst_state", 32'(bus.state), 32'd0);
    check_eq("midgo_rst_time", 32'(bus.time_ms), 32'd0);
    check_eq("midgo_rst_best", 32'(bus.best_ms), 32'd9999);
    check_eq("midgo_rst_led", 32'(bus.led_go), 32'd0);
    rst = 1'b0;
    step();
    step();
    check_eq("held_start_after_rst", 32'(bus.state), 32'd0);
    bus.start_btn = 1'b0;
    step();
    press_start();
    check_eq("press_after_release", 32'(bus.state), 32'd1);

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reaction_ctrl.md
REACTION_CTRL -- requirements
Module: reaction_ctrl

Interface
REQ-001 Parameter: MIN_DELAY_MS, 1000, minimum random wait before GO, in ms ticks.
REQ-002 Parameter: MAX_COUNT, 9999, elapsed-time saturation value (4 BCD digits).
REQ-003 Port: clk  input  1  single clock for all logic; every register updates on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: tick  input  1  1 ms enable pulse from the clock divider, one clk wide.
REQ-006 Port: rand_in  input  15  free-running LFSR value.
REQ-007 Port: start_btn  input  1  start level, active-high, already synchronized.
REQ-008 Port: stop_btn  input  1  stop level, active-high, already synchronized.
REQ-009 Port: led_go  output  1  high only in GO.
REQ-010 Port: count_en  output  1  high only in GO; enables the downstream BCD counter.
REQ-011 Port: count_clr  output  1  one-clk pulse on every entry to ARM.
REQ-012 Port: time_ms  output  14  binary elapsed/result time.
REQ-013 Port: best_ms  output  14  smallest valid result since reset.
REQ-014 Port: foul  output  1  high only in FOUL.
REQ-015 Port: state  output  3  IDLE=0, ARM=1, GO=2, DONE=3, FOUL=4.

Function
REQ-016 Presses are rising edges of start_btn/stop_btn; edge-detect history registers reset to 1, so a button held through reset registers no press until released.
REQ-017 IDLE, DONE or FOUL + start press -> ARM next clk; delay counter loaded with MIN_DELAY_MS + rand_in[11:0] (range 1000..5095); time_ms cleared to 0; count_clr pulses.
REQ-018 ARM: each tick decrements the delay counter; the tick that brings it to 0 moves the FSM to GO on the next clk, so GO is entered after exactly the loaded number of ticks.
REQ-019 ARM + stop press -> FOUL; stop takes priority over a coincident final tick.
REQ-020 GO: each tick increments time_ms by 1.
REQ-021 GO + stop press -> DONE; if tick and stop coincide, stop wins and that tick is not counted.
REQ-022 GO: when time_ms reaches MAX_COUNT, the FSM moves to DONE on the next clk with time_ms held at MAX_COUNT, and best_ms is left unchanged.
REQ-023 On a stop-driven GO->DONE transition, best_ms <= time_ms if time_ms < best_ms.
REQ-024 DONE holds time_ms; FOUL forces time_ms=0.
REQ-025 Start presses in ARM/GO are ignored; stop presses in IDLE, DONE and FOUL are ignored.
REQ-026 All outputs are registered or decoded directly from state; no combinational path from any input to any output.

Reset
REQ-027 On rst: state=IDLE, delay counter=0, time_ms=0, best_ms=MAX_COUNT, led_go=0, count_en=0, count_clr=0, foul=0.
REQ-028 rst asserted in any state, including mid-ARM or mid-GO, takes effect on the next clk edge and discards the round in progress.

Structure
REQ-029 Package reaction_pkg holds: state encoding constants, the 14-bit time width, and the 12-bit rand slice width.
REQ-030 Sub-module edge_detect (1-bit rising-edge detector, history register reset to 1) is instantiated twice, once for start and once for stop.
REQ-031 Delay counter is 13 bits; time_ms and best_ms are 14 bits; no arithmetic overflows within these widths.

Verification
REQ-032 rand_in=0, start press, ticks every 10 clk -> GO entered one clk after tick 1000; count_clr pulses once.
REQ-033 rand_in=15'h7FFF, start press -> GO entered after exactly 5095 ticks.
REQ-034 Stop after 250 GO ticks -> DONE, time_ms=250, best_ms=250; next round stopped at 300 -> best_ms stays 250.
REQ-035 Stop press during ARM -> FOUL, foul=1, led_go=0, time_ms=0; then start press -> ARM with foul=0.
REQ-036 No stop in GO -> DONE at time_ms=9999, best_ms unchanged; stop and tick in the same clk at time_ms=42 -> result 42.
REQ-037 rst mid-GO at time_ms=500 -> next clk: state=IDLE, time_ms=0, best_ms=9999; a start held through rst produces no press.
